// File: rtl/lsu_pkg.sv
// Shared LSU types: arbiter FSM states, the registered cache request and the default starvation limit.
// Request fields are sized for the widest supported port; users cast to their own widths.
package lsu_pkg;

    localparam int STARVE_LIMIT_DEF = 4;
    localparam int REQ_ADDR_W       = 32;
    localparam int REQ_TAG_W        = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [REQ_ADDR_W-1:0] addr;
        logic [31:0]           wdata;
        logic [3:0]            byte_en;
        logic [REQ_TAG_W-1:0]  tag;
        logic                  is_load;
    } mem_req_t;

endpackage

// File: rtl/dcarb_starve_ctr.sv
// Counts consecutive load grants while a store is waiting; flags when the store must be served.
// Latency: starve is a registered count compared combinationally; no backpressure of its own.
// Backpressure: none, it only steers the arbiter's grant choice.
module dcarb_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic st_valid,
    input  logic ld_grant,
    input  logic st_grant,
    output logic starve
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (st_grant || !st_valid) begin
            cnt <= '0;
        end else if (ld_grant && (cnt != CW'(LIMIT))) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign starve = (cnt == CW'(LIMIT));

endmodule

// File: rtl/dcache_port_arbiter.sv
// Arbitrates load and committed-store requests onto one D-Cache port, one transaction at a time.
// Latency: request on dc_* the cycle after transfer; load response one cycle after a non-stalled cycle.
// Backpressure: ready only in IDLE for the granted channel; dc_stall holds the transaction. Option: DCACHE_ARB_STARVE_EN.
import lsu_pkg::*;

module dcache_port_arbiter #(
    parameter int ADDR_W       = 30,
    parameter int TAG_W        = 5,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [TAG_W-1:0]  ld_tag,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_wdata,
    input  logic [3:0]        st_byte_en,
    output logic              dc_read_req,
    output logic              dc_write_req,
    output logic [ADDR_W-1:0] dc_addr,
    output logic [31:0]       dc_wdata,
    output logic [3:0]        dc_byte_w_en,
    input  logic [31:0]       dc_rdata,
    input  logic              dc_stall,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic [TAG_W-1:0]  resp_tag
);

    arb_state_t       state_q, state_d;
    mem_req_t         req_q, req_d;
    logic             starve;
    logic             grant_ld, grant_st;
    logic             ld_xfer, st_xfer;
    logic             active, done;
    logic             flush_pend;
    logic             resp_vld_q;
    logic [31:0]      resp_data_q;
    logic [TAG_W-1:0] resp_tag_q;

`ifdef DCACHE_ARB_STARVE_EN
    dcarb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .st_valid (st_valid),
        .ld_grant (ld_xfer),
        .st_grant (st_xfer),
        .starve   (starve)
    );
`else
    logic unused_starve_cfg;
    assign unused_starve_cfg = (STARVE_LIMIT > 0);
    assign starve            = 1'b0;
`endif

    // Ready is withheld during reset and flush so nothing is accepted and then lost.
    assign grant_ld = ld_valid && !(starve && st_valid);
    assign grant_st = st_valid && !grant_ld;
    assign ld_ready = rst && !flush && (state_q == IDLE) && grant_ld;
    assign st_ready = rst && !flush && (state_q == IDLE) && grant_st;
    assign ld_xfer  = ld_valid && ld_ready;
    assign st_xfer  = st_valid && st_ready;
    assign active   = (state_q == ISSUE) || (state_q == WAIT);
    assign done     = active && !dc_stall;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        case (state_q)
            IDLE: begin
                if (ld_xfer) begin
                    req_d.addr    = 32'(ld_addr);
                    req_d.wdata   = '0;
                    req_d.byte_en = '0;
                    req_d.tag     = 8'(ld_tag);
                    req_d.is_load = 1'b1;
                    state_d       = ISSUE;
                end else if (st_xfer) begin
                    req_d.addr    = 32'(st_addr);
                    req_d.wdata   = st_wdata;
                    req_d.byte_en = st_byte_en;
                    req_d.tag     = '0;
                    req_d.is_load = 1'b0;
                    state_d       = ISSUE;
                end
            end
            ISSUE:   state_d = dc_stall ? WAIT : IDLE;
            WAIT:    state_d = dc_stall ? WAIT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            req_q       <= '0;
            flush_pend  <= 1'b0;
            resp_vld_q  <= 1'b0;
            resp_data_q <= '0;
            resp_tag_q  <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            resp_vld_q <= done && req_q.is_load && !flush && !flush_pend;
            // A flush seen at any point of an outstanding load kills its response.
            if (state_q == IDLE) begin
                flush_pend <= 1'b0;
            end else if (flush) begin
                flush_pend <= 1'b1;
            end
            if (done && req_q.is_load) begin
                resp_data_q <= dc_rdata;
                resp_tag_q  <= TAG_W'(req_q.tag);
            end
        end
    end

    assign dc_read_req  = active && req_q.is_load;
    assign dc_write_req = active && !req_q.is_load;
    assign dc_addr      = active ? ADDR_W'(req_q.addr) : '0;
    assign dc_wdata     = active ? req_q.wdata : '0;
    assign dc_byte_w_en = active ? req_q.byte_en : '0;
    assign resp_valid   = resp_vld_q && !flush;
    assign resp_data    = resp_data_q;
    assign resp_tag     = resp_tag_q;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed self-checking bench for dcache_port_arbiter; honours DCACHE_ARB_STARVE_EN for the grant pattern.
module tb_dcache_port_arbiter;

    localparam int ADDR_W = 30;
    localparam int TAG_W  = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              ld_valid, ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [TAG_W-1:0]  ld_tag;
    logic              st_valid, st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_wdata;
    logic [3:0]        st_byte_en;
    logic              dc_read_req, dc_write_req;
    logic [ADDR_W-1:0] dc_addr;
    logic [31:0]       dc_wdata;
    logic [3:0]        dc_byte_w_en;
    logic [31:0]       dc_rdata;
    logic              dc_stall;
    logic              resp_valid;
    logic [31:0]       resp_data;
    logic [TAG_W-1:0]  resp_tag;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dcache_port_arbiter #(
        .ADDR_W       (ADDR_W),
        .TAG_W        (TAG_W),
        .STARVE_LIMIT (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_addr      (ld_addr),
        .ld_tag       (ld_tag),
        .st_valid     (st_valid),
        .st_ready     (st_ready),
        .st_addr      (st_addr),
        .st_wdata     (st_wdata),
        .st_byte_en   (st_byte_en),
        .dc_read_req  (dc_read_req),
        .dc_write_req (dc_write_req),
        .dc_addr      (dc_addr),
        .dc_wdata     (dc_wdata),
        .dc_byte_w_en (dc_byte_w_en),
        .dc_rdata     (dc_rdata),
        .dc_stall     (dc_stall),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .resp_tag     (resp_tag)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no end, want finish");
        $fatal(1);
    end

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; ld_valid = 1'b1; st_valid = 1'b1;
        ld_addr = '0; ld_tag = '0; st_addr = '0; st_wdata = '0; st_byte_en = '0;
        dc_rdata = '0; dc_stall = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ld_ready: got %b want 0", ld_ready); end
        n_cmp++; if (st_ready !== 1'b0) begin n_bad++; $display("FAIL rst_st_ready: got %b want 0", st_ready); end
        n_cmp++; if ({dc_read_req, dc_write_req} !== 2'b00) begin n_bad++; $display("FAIL rst_dc_req: got %b want 00", {dc_read_req, dc_write_req}); end
        n_cmp++; if (dc_addr !== '0) begin n_bad++; $display("FAIL rst_dc_addr: got %h want 0", dc_addr); end
        n_cmp++; if (resp_valid !== 1'b0 || resp_data !== 32'h0) begin n_bad++; $display("FAIL rst_resp: got %b/%h want 0/0", resp_valid, resp_data); end
        @(negedge clk);
        ld_valid = 1'b0; st_valid = 1'b0; rst = 1'b1; #1;
        n_cmp++; if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL idle_no_valid_ready: got %b want 0", ld_ready); end
    endtask

    task automatic test_load();
        @(negedge clk);
        ld_valid = 1'b1; ld_addr = 30'h10; ld_tag = 5'd3; dc_rdata = 32'hDEADBEEF; dc_stall = 1'b0; #1;
        n_cmp++; if (ld_ready !== 1'b1 || st_ready !== 1'b0) begin n_bad++; $display("FAIL load_ready: got %b%b want 10", ld_ready, st_ready); end
        @(negedge clk);
        ld_valid = 1'b0; #1;
        n_cmp++; if (dc_read_req !== 1'b1 || dc_write_req !== 1'b0) begin n_bad++; $display("FAIL load_req: got rd=%b wr=%b want 1 0", dc_read_req, dc_write_req); end
        n_cmp++; if (dc_addr !== 30'h10) begin n_bad++; $display("FAIL load_addr: got %h want 10", dc_addr); end
        n_cmp++; if (dc_wdata !== 32'h0 || dc_byte_w_en !== 4'h0) begin n_bad++; $display("FAIL load_wdata_zero: got %h/%h want 0/0", dc_wdata, dc_byte_w_en); end
        n_cmp++; if (resp_valid !== 1'b0 || ld_ready !== 1'b0) begin n_bad++; $display("FAIL load_issue_quiet: got resp=%b rdy=%b want 0 0", resp_valid, ld_ready); end
        @(negedge clk); #1;
        n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL load_resp_valid: got %b want 1", resp_valid); end
        n_cmp++; if (resp_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL load_resp_data: got %h want deadbeef", resp_data); end
        n_cmp++; if (resp_tag !== 5'd3) begin n_bad++; $display("FAIL load_resp_tag: got %0d want 3", resp_tag); end
        n_cmp++; if (dc_read_req !== 1'b0) begin n_bad++; $display("FAIL load_req_drop: got %b want 0", dc_read_req); end
        @(negedge clk); #1;
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL load_resp_pulse: got %b want 0", resp_valid); end
    endtask

    task automatic test_store_stall();
        @(negedge clk);
        st_valid = 1'b1; st_addr = 30'h20; st_wdata = 32'h12345678; st_byte_en = 4'b0011; dc_stall = 1'b1; #1;
        n_cmp++; if (st_ready !== 1'b1 || ld_ready !== 1'b0) begin n_bad++; $display("FAIL store_ready: got st=%b ld=%b want 1 0", st_ready, ld_ready); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            st_valid = 1'b0; #1;
            n_cmp++; if (dc_write_req !== 1'b1 || dc_read_req !== 1'b0) begin n_bad++; $display("FAIL store_req_c%0d: got wr=%b rd=%b want 1 0", i, dc_write_req, dc_read_req); end
            n_cmp++; if (dc_addr !== 30'h20 || dc_wdata !== 32'h12345678 || dc_byte_w_en !== 4'b0011) begin n_bad++; $display("FAIL store_hold_c%0d: got %h %h %b want 20 12345678 0011", i, dc_addr, dc_wdata, dc_byte_w_en); end
            n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL store_no_resp_c%0d: got %b want 0", i, resp_valid); end
            if (i == 3) dc_stall = 1'b0;
        end
        @(negedge clk); #1;
        n_cmp++; if (dc_write_req !== 1'b0 || resp_valid !== 1'b0) begin n_bad++; $display("FAIL store_done: got wr=%b resp=%b want 0 0", dc_write_req, resp_valid); end
        ld_valid = 1'b1; ld_addr = 30'h11; ld_tag = 5'd1; #1;
        n_cmp++; if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL store_back_idle: got ld_ready=%b want 1", ld_ready); end
        @(negedge clk); ld_valid = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (resp_valid !== 1'b1 || resp_tag !== 5'd1) begin n_bad++; $display("FAIL post_store_load: got %b/%0d want 1/1", resp_valid, resp_tag); end
    endtask

    task automatic test_starvation();
        int got = 0;
        logic exp_st;
        @(negedge clk);
        ld_valid = 1'b1; st_valid = 1'b1; ld_addr = 30'h40; ld_tag = 5'd9;
        st_addr = 30'h50; st_wdata = 32'hA5A5A5A5; st_byte_en = 4'hF; dc_stall = 1'b0;
        for (int c = 0; c < 40 && got < 10; c++) begin
            #1;
            n_cmp++; if (ld_ready && st_ready) begin n_bad++; $display("FAIL grant_both_c%0d: got 11 want one-hot", c); end
            if (ld_ready || st_ready) begin
`ifdef DCACHE_ARB_STARVE_EN
                exp_st = ((got % 5) == 4);
`else
                exp_st = 1'b0;
`endif
                n_cmp++; if (st_ready !== exp_st || ld_ready !== !exp_st) begin n_bad++; $display("FAIL grant_seq_%0d: got ld=%b st=%b want st=%b", got, ld_ready, st_ready, exp_st); end
                got++;
            end
            @(negedge clk);
        end
        ld_valid = 1'b0; st_valid = 1'b0;
        n_cmp++; if (got != 10) begin n_bad++; $display("FAIL grant_timeout: got %0d grants want 10", got); end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_flush();
        @(negedge clk);
        ld_valid = 1'b1; ld_addr = 30'h44; ld_tag = 5'd7; flush = 1'b1; dc_rdata = 32'h0BADF00D; #1;
        n_cmp++; if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL flush_idle_block: got %b want 0", ld_ready); end
        @(negedge clk);
        flush = 1'b0; dc_stall = 1'b1; #1;
        n_cmp++; if (ld_ready !== 1'b1 || dc_read_req !== 1'b0) begin n_bad++; $display("FAIL flush_idle_nodrop: got rdy=%b rd=%b want 1 0", ld_ready, dc_read_req); end
        @(negedge clk);
        ld_valid = 1'b0; flush = 1'b1; #1;
        n_cmp++; if (dc_read_req !== 1'b1) begin n_bad++; $display("FAIL flush_issue_req: got %b want 1", dc_read_req); end
        @(negedge clk);
        flush = 1'b0; #1;
        n_cmp++; if (dc_read_req !== 1'b1 || dc_addr !== 30'h44 || resp_valid !== 1'b0) begin n_bad++; $display("FAIL flush_wait_hold: got rd=%b addr=%h resp=%b want 1 44 0", dc_read_req, dc_addr, resp_valid); end
        @(negedge clk); #1;
        n_cmp++; if (dc_read_req !== 1'b1) begin n_bad++; $display("FAIL flush_wait_hold2: got %b want 1", dc_read_req); end
        dc_stall = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (resp_valid !== 1'b0 || dc_read_req !== 1'b0) begin n_bad++; $display("FAIL flush_suppress: got resp=%b rd=%b want 0 0", resp_valid, dc_read_req); end
        // normal load after the flushed one
        ld_valid = 1'b1; ld_addr = 30'h48; ld_tag = 5'd2; dc_rdata = 32'hCAFEF00D; #1;
        n_cmp++; if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL flush_next_ready: got %b want 1", ld_ready); end
        @(negedge clk); ld_valid = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (resp_valid !== 1'b1 || resp_data !== 32'hCAFEF00D || resp_tag !== 5'd2) begin n_bad++; $display("FAIL flush_next_resp: got %b %h %0d want 1 cafef00d 2", resp_valid, resp_data, resp_tag); end
        // flush in the response cycle itself
        @(negedge clk);
        ld_valid = 1'b1; ld_tag = 5'd5; dc_rdata = 32'h11112222;
        @(negedge clk); ld_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1; #1;
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL flush_resp_cycle: got %b want 0", resp_valid); end
        // flush coinciding with completion
        @(negedge clk);
        flush = 1'b0; ld_valid = 1'b1; ld_tag = 5'd6; #1;
        n_cmp++; if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL flush_coin_ready: got %b want 1", ld_ready); end
        @(negedge clk);
        ld_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; #1;
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL flush_coincide: got %b want 0", resp_valid); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        st_valid = 1'b1; st_addr = 30'h30; st_wdata = 32'hFFFF0000; st_byte_en = 4'hF; dc_stall = 1'b1; #1;
        n_cmp++; if (st_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_st_ready: got %b want 1", st_ready); end
        @(negedge clk); st_valid = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (dc_write_req !== 1'b1) begin n_bad++; $display("FAIL rmid_in_wait: got %b want 1", dc_write_req); end
        rst = 1'b0; ld_valid = 1'b1; ld_tag = 5'd4;
        @(negedge clk); #1;
        n_cmp++; if ({dc_read_req, dc_write_req, dc_byte_w_en} !== 6'b0 || dc_addr !== '0 || dc_wdata !== 32'h0) begin n_bad++; $display("FAIL rmid_dc_zero: got %b%b %h %h %h want all 0", dc_read_req, dc_write_req, dc_addr, dc_wdata, dc_byte_w_en); end
        n_cmp++; if ({ld_ready, st_ready, resp_valid} !== 3'b000) begin n_bad++; $display("FAIL rmid_ctl_zero: got %b want 000", {ld_ready, st_ready, resp_valid}); end
        rst = 1'b1; dc_stall = 1'b0; #1;
        n_cmp++; if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_idle_ready: got %b want 1", ld_ready); end
        @(negedge clk);
        ld_valid = 1'b0; rst = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (resp_valid !== 1'b0 || resp_tag !== '0) begin n_bad++; $display("FAIL rmid_no_pending_resp: got %b/%0d want 0/0", resp_valid, resp_tag); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_load();
        test_store_stall();
        test_starvation();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dcache_port_arbiter.md
DCACHE_PORT_ARBITER -- requirements
Module: dcache_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 30, D-Cache word-address width.
REQ-002 SHALL have parameter TAG_W, default 5, ROB tag width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, maximum consecutive load grants while a store waits.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on posedge clk.
REQ-005 SHALL have port rst, input, 1, synchronous active-low reset (rst==0 at posedge clk resets).
REQ-006 SHALL have port flush, input, 1, pipeline flush; cancels the load result only.
REQ-007 SHALL have ports ld_valid/ld_ready, in/out, 1 each; ld_addr, in, ADDR_W; ld_tag, in, TAG_W, giving the load request channel.
REQ-008 SHALL have ports st_valid/st_ready, in/out, 1 each; st_addr, in, ADDR_W; st_wdata, in, 32; st_byte_en, in, 4, giving the committed-store channel.
REQ-009 SHALL have ports dc_read_req, dc_write_req, out, 1 each; dc_addr, out, ADDR_W; dc_wdata, out, 32; dc_byte_w_en, out, 4, driving the D-Cache.
REQ-010 SHALL have ports dc_rdata, in, 32; dc_stall, in, 1, the cache busy/miss indication.
REQ-011 SHALL have ports resp_valid, out, 1; resp_data, out, 32; resp_tag, out, TAG_W, carrying the load result broadcast.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE and WAIT; only one transaction outstanding.
REQ-013 SHALL assert ld_ready/st_ready combinationally only in IDLE, only for the granted channel; transfer = valid&&ready.
REQ-014 SHALL grant in IDLE: load if ld_valid, unless store-priority condition (REQ-020) holds; else store if st_valid; never both.
REQ-015 SHALL register the accepted request; IDLE->ISSUE on transfer; dc_read_req or dc_write_req =1 from the next cycle with dc_addr/dc_wdata/dc_byte_w_en held stable.
REQ-016 SHALL treat a dc_*_req cycle with dc_stall==0 as completion; if dc_stall==1 go ISSUE->WAIT holding all dc_* outputs until the first cycle with dc_stall==0.
REQ-017 SHALL on load completion in cycle T pulse resp_valid for one cycle at T+1 with resp_data=dc_rdata sampled at T and resp_tag=the accepted ld_tag.
REQ-018 SHALL return to IDLE the cycle after completion; minimum back-to-back spacing is 2 cycles per transaction.
REQ-019 SHALL keep dc_wdata=0 and dc_byte_w_en=0 for loads, and resp_valid=0 for stores.
REQ-020 SHALL count consecutive load grants while st_valid==1 (saturating at STARVE_LIMIT); at count==STARVE_LIMIT grant the store; clear count on any store grant or when st_valid==0.
REQ-021 SHALL on flush: in IDLE, drop nothing (no transfer that cycle); during an outstanding load, let the cache transaction finish but suppress its resp_valid; outstanding stores finish and are unaffected.
REQ-022 SHALL suppress resp_valid if flush and completion coincide, or if flush is asserted in the resp_valid cycle itself.

Reset
REQ-023 SHALL on rst==0 set FSM=IDLE, starve count=0, flush-pending=0, and all outputs 0 (ld_ready, st_ready, dc_*, resp_*), including mid-transaction; no pending response survives.

Configuration
REQ-024 SHALL, when macro DCACHE_ARB_STARVE_EN is defined, include the starvation counter of REQ-020; when undefined, use strict load priority and omit the counter logic; all other behaviour is identical.

Structure
REQ-025 SHALL take the default STARVE_LIMIT, the FSM state enum and a mem_req_t struct (addr, wdata, byte_en, tag, is_load) from shared package lsu_pkg.
REQ-026 SHALL place the starvation counter in a sub-module named dcarb_starve_ctr, instantiated only under DCACHE_ARB_STARVE_EN.

Verification
REQ-027 SHALL cover: load addr=0x10, tag=3, dc_stall=0, dc_rdata=0xDEADBEEF -> dc_read_req one cycle after transfer, then resp_valid=1 with data 0xDEADBEEF and tag 3.
REQ-028 SHALL cover: store addr=0x20, wdata=0x12345678, byte_en=4'b0011, dc_stall high 3 cycles -> dc_write_req and all dc_* stable for 4 cycles, no resp_valid, IDLE afterwards.
REQ-029 SHALL cover: ld_valid and st_valid held high continuously with macro defined, STARVE_LIMIT=4 -> grant sequence L,L,L,L,S repeating; with macro undefined -> loads only.
REQ-030 SHALL cover: flush during load in WAIT (dc_stall high) -> dc_read_req held to completion, resp_valid never asserted, next request accepted normally.
REQ-031 SHALL cover: rst=0 while in WAIT for a store -> all outputs 0 at the next cycle, FSM IDLE, ld_ready=1 when ld_valid=1 after rst returns 1.
